// File: rtl/mem_arbiter_pkg.sv
// Shared CPU/memory types for the RAM arbiter: word, RAM status, grant state
// and the request payload the arbiter presents to the RAM.
package mem_arbiter_pkg;

  localparam int unsigned WORD_W   = 32;
  localparam int unsigned STREAK_W = 4;

  typedef logic [WORD_W-1:0]   word_t;
  typedef logic [STREAK_W-1:0] streak_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IGRANT = 2'd1,
    DGRANT = 2'd2
  } arb_state_t;

  // One RAM transaction as driven by the arbiter.
  typedef struct packed {
    logic  ren;
    logic  wen;
    word_t addr;
    word_t store;
  } ram_req_t;

endpackage

// File: rtl/mem_arbiter.sv
// Grants the single-port RAM to instruction fetch or data access, data first.
// Optional anti-starvation streak guard under `ARB_FAIRNESS_EN.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned MAX_DSTREAK = 4
) (
  input  logic      CLK,
  input  logic      nRST,
  input  logic      iREN,
  input  word_t     iaddr,
  output logic      iwait,
  output word_t     iload,
  input  logic      dREN,
  input  logic      dWEN,
  input  word_t     daddr,
  input  word_t     dstore,
  output logic      dwait,
  output word_t     dload,
  output logic      ramREN,
  output logic      ramWEN,
  output word_t     ramaddr,
  output word_t     ramstore,
  input  word_t     ramload,
  input  ramstate_t ramstate
);

  if ((MAX_DSTREAK == 0) || (MAX_DSTREAK > 15)) begin : g_bad_max_dstreak
    $error("MAX_DSTREAK must be in 1..15");
  end

  arb_state_t state;
  ram_req_t   ram_req;
  logic       data_req;
  logic       ram_ack;
  logic       i_ack;
  logic       d_ack;
  logic       force_i;

  assign data_req = dREN | dWEN;
  assign ram_ack  = (ramstate == ACCESS);
  assign i_ack    = (state == IGRANT) && ram_ack;
  assign d_ack    = (state == DGRANT) && ram_ack;

  assign iwait = iREN && !i_ack;
  assign dwait = data_req && !d_ack;
  assign iload = ramload;
  assign dload = ramload;

`ifdef ARB_FAIRNESS_EN
  localparam streak_t MAX_S = streak_t'(MAX_DSTREAK);

  streak_t streak;

  // Consecutive data completions seen while a fetch was left waiting.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      streak <= '0;
    end else if (iREN && i_ack) begin
      streak <= '0;
    end else if (data_req && d_ack) begin
      if (!iREN) begin
        streak <= '0;
      end else if (streak != MAX_S) begin
        streak <= streak + streak_t'(1);
      end
    end
  end

  assign force_i = iREN && (streak == MAX_S);
`else
  assign force_i = 1'b0;
`endif

  // Grant state; every completion or abandon returns through IDLE.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (force_i)       state <= IGRANT;
          else if (data_req) state <= DGRANT;
          else if (iREN)     state <= IGRANT;
        end
        IGRANT: begin
          if (!iREN || ram_ack) state <= IDLE;
        end
        DGRANT: begin
          if (!data_req || ram_ack) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // RAM request follows the granted requester; a write suppresses the read.
  always_comb begin
    ram_req = '0;
    case (state)
      IGRANT: begin
        ram_req.ren  = iREN;
        ram_req.addr = iaddr;
      end
      DGRANT: begin
        ram_req.addr = daddr;
        ram_req.wen  = dWEN;
        ram_req.ren  = dREN && !dWEN;
        if (dWEN) ram_req.store = dstore;
      end
      default: ;
    endcase
  end

  assign ramREN   = ram_req.ren;
  assign ramWEN   = ram_req.wen;
  assign ramaddr  = ram_req.addr;
  assign ramstore = ram_req.store;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a stub RAM, two requesters and a monitor
// that checks every completion against expectations queued at issue time.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  typedef struct packed {
    logic  we;
    word_t addr;
    word_t data;
  } exp_t;

  logic      CLK, nRST, iREN, dREN, dWEN;
  word_t     iaddr, daddr, dstore, ramload;
  logic      iwait, dwait, ramREN, ramWEN;
  word_t     iload, dload, ramaddr, ramstore;
  ramstate_t ramstate;

  int    tests = 0;
  int    failures = 0;
  int    cyc = 0;
  int    i_cnt = 0, d_cnt = 0;
  int    i_done_cyc = 0, d_done_cyc = 0;
  int    force_lat = 0;
  bit    force_err = 0;
  exp_t  iq[$];
  exp_t  dq[$];
  word_t ram_mem[word_t];
  word_t ref_mem[word_t];

  mem_arbiter dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial forever begin
    @(posedge CLK);
    cyc++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got time %0t required earlier end", $time);
    $fatal(1);
  end

  function automatic word_t init_val(input word_t a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
  endfunction

  function automatic word_t ref_read(input word_t a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  function automatic word_t stub_read(input word_t a);
    return ram_mem.exists(a) ? ram_mem[a] : init_val(a);
  endfunction

  task automatic check(input string name, input word_t act, input word_t exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h required 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic issue_i(input word_t a);
    exp_t e;
    e.we = 1'b0; e.addr = a; e.data = ref_read(a);
    iq.push_back(e);
    iREN = 1'b1; iaddr = a;
  endtask

  task automatic issue_d(input logic we, input word_t a, input word_t v, input logic both);
    exp_t e;
    e.we = we; e.addr = a; e.data = we ? v : ref_read(a);
    if (we) ref_mem[a] = v;
    dq.push_back(e);
    dWEN = we; dREN = we ? both : 1'b1; daddr = a; dstore = v;
  endtask

  task automatic wait_i(input int budget, input bit drop);
    bit done = 0;
    for (int n = 0; n < budget && !done; n++) begin
      @(negedge CLK); #1;
      if (iREN && !iwait) done = 1;
    end
    check("i_complete_in_budget", word_t'(done), 32'd1);
    @(posedge CLK); #1;
    if (drop) iREN = 1'b0;
  endtask

  task automatic wait_d(input int budget, input bit drop);
    bit done = 0;
    for (int n = 0; n < budget && !done; n++) begin
      @(negedge CLK); #1;
      if ((dREN || dWEN) && !dwait) done = 1;
    end
    check("d_complete_in_budget", word_t'(done), 32'd1);
    @(posedge CLK); #1;
    if (drop) begin dREN = 1'b0; dWEN = 1'b0; end
  endtask

  // Stub RAM: picks a latency per grant, answers ACCESS when it expires.
  initial begin
    bit active = 0;
    int left = 0;
    ramstate = FREE;
    ramload  = '0;
    forever begin
      @(negedge CLK);
      if (!nRST || !(ramREN || ramWEN)) begin
        ramstate = FREE;
        active = 0;
      end else begin
        if (!active) begin
          active = 1;
          left = (force_lat >= 0) ? force_lat : int'($urandom_range(0, 3));
        end
        if (force_err) begin
          ramstate = ERROR;
        end else if (left == 0) begin
          if (ramWEN) ram_mem[ramaddr] = ramstore;
          ramload  = stub_read(ramaddr);
          ramstate = ACCESS;
          active = 0;
        end else begin
          left--;
          if (force_lat >= 0) ramstate = BUSY;
          else case ($urandom_range(0, 2))
            0:       ramstate = FREE;
            1:       ramstate = BUSY;
            default: ramstate = ERROR;
          endcase
        end
      end
    end
  end

  // Monitor: pops the scoreboard on every completion the DUT signals.
  initial forever begin
    exp_t e;
    @(negedge CLK); #1;
    check("ram_rw_exclusive", word_t'(ramREN & ramWEN), 32'd0);
    if (nRST && iREN && !iwait) begin
      if (iq.size() == 0) begin
        tests++; failures++;
        $display("FAIL i_unexpected: completion at addr 0x%08h, required none pending", ramaddr);
      end else begin
        e = iq.pop_front();
        check("iload", iload, e.data);
        check("i_ramaddr", ramaddr, e.addr);
        check("i_ramREN", word_t'(ramREN), 32'd1);
      end
      i_cnt++; i_done_cyc = cyc;
    end
    if (nRST && (dREN || dWEN) && !dwait) begin
      if (dq.size() == 0) begin
        tests++; failures++;
        $display("FAIL d_unexpected: completion at addr 0x%08h, required none pending", ramaddr);
      end else begin
        e = dq.pop_front();
        check("d_ramaddr", ramaddr, e.addr);
        if (e.we) begin
          check("d_ramWEN", word_t'(ramWEN), 32'd1);
          check("d_ramREN_on_write", word_t'(ramREN), 32'd0);
          check("d_ramstore", ramstore, e.data);
        end else begin
          check("dload", dload, e.data);
          check("d_ramREN", word_t'(ramREN), 32'd1);
        end
      end
      d_cnt++; d_done_cyc = cyc;
    end
  end

  initial begin
    int start, d0, i0;
    bit i_flag;

    // Reset with both requesters active.
    nRST = 1'b0; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
    iaddr = '0; daddr = '0; dstore = '0;
    force_lat = 0;
    issue_i(32'h44);
    issue_d(1'b0, 32'h100, 32'h0, 1'b0);
    repeat (3) @(posedge CLK);
    @(negedge CLK); #1;
    check("rst_ramREN", word_t'(ramREN), 32'd0);
    check("rst_ramWEN", word_t'(ramWEN), 32'd0);
    check("rst_ramaddr", ramaddr, 32'd0);
    check("rst_iwait", word_t'(iwait), 32'd1);
    check("rst_dwait", word_t'(dwait), 32'd1);
    nRST = 1'b1;
    @(posedge CLK); #1;
    check("rel_dgrant_ramREN", word_t'(ramREN), 32'd1);
    check("rel_dgrant_ramaddr", ramaddr, 32'h100);
    start = cyc;
    fork
      wait_d(50, 1'b1);
      wait_i(50, 1'b1);
    join
    check("rel_d_latency", word_t'(d_done_cyc - start), 32'd0);
    check("rel_i_after_bubble", word_t'(i_done_cyc - d_done_cyc), 32'd2);

    // Single fetch held across two completions: one-cycle wait drop, then bubble.
    ram_mem[32'h40] = 32'h8C220004;
    ref_mem[32'h40] = 32'h8C220004;
    issue_i(32'h40);
    issue_i(32'h40);
    @(negedge CLK); #1;
    check("f_idle_iwait", word_t'(iwait), 32'd1);
    check("f_idle_ramREN", word_t'(ramREN), 32'd0);
    @(negedge CLK); #1;
    check("f_grant_iwait", word_t'(iwait), 32'd0);
    check("f_grant_iload", iload, 32'h8C220004);
    check("f_grant_ramaddr", ramaddr, 32'h40);
    @(negedge CLK); #1;
    check("f_bubble_iwait", word_t'(iwait), 32'd1);
    check("f_bubble_ramREN", word_t'(ramREN), 32'd0);
    @(negedge CLK); #1;
    check("f_second_iwait", word_t'(iwait), 32'd0);
    @(posedge CLK); #1;
    iREN = 1'b0;

    // Conflict: both assert together, RAM two BUSY cycles per access.
    force_lat = 2;
    start = cyc;
    issue_d(1'b0, 32'h100, 32'h0, 1'b0);
    issue_i(32'h48);
    fork
      wait_d(50, 1'b1);
      wait_i(50, 1'b1);
    join
    check("cf_d_latency", word_t'(d_done_cyc - start), 32'd3);
    check("cf_i_after_d", word_t'(i_done_cyc - d_done_cyc), 32'd4);

    // Write priority with dREN and dWEN both high, then read back.
    force_lat = 1;
    issue_d(1'b1, 32'h200, 32'hDEADBEEF, 1'b1);
    @(posedge CLK); #1;
    check("wp_ramWEN", word_t'(ramWEN), 32'd1);
    check("wp_ramREN", word_t'(ramREN), 32'd0);
    check("wp_ramstore", ramstore, 32'hDEADBEEF);
    check("wp_ramaddr", ramaddr, 32'h200);
    wait_d(50, 1'b1);
    issue_d(1'b0, 32'h200, 32'h0, 1'b0);
    wait_d(50, 1'b1);

    force_lat = 0;
`ifdef ARB_FAIRNESS_EN
    // Held fetch against back-to-back data: exactly MAX_DSTREAK data wins, twice.
    for (int r = 0; r < 2; r++) begin
      d0 = d_cnt;
      i_flag = 0;
      issue_i(32'h4C);
      fork
        begin
          wait_i(100, 1'b1);
          check("fair_dcount", word_t'(d_cnt - d0), 32'd4);
          i_flag = 1;
        end
        begin
          while (!i_flag) begin
            issue_d(1'b0, 32'h1000 + (word_t'($urandom_range(0, 15)) << 2), 32'h0, 1'b0);
            wait_d(100, 1'b1);
          end
        end
      join
    end
`else
    // Strict priority: back-to-back data keeps a held fetch waiting.
    i0 = i_cnt;
    issue_i(32'h4C);
    for (int k = 0; k < 8; k++) begin
      issue_d(1'b0, 32'h1000 + (word_t'($urandom_range(0, 15)) << 2), 32'h0, 1'b0);
      wait_d(100, 1'b1);
    end
    check("strict_prio_starved", word_t'(i_cnt - i0), 32'd0);
    wait_i(20, 1'b1);
    check("strict_prio_released", word_t'(i_cnt - i0), 32'd1);
`endif

    // ERROR keeps the grant without completing; dropping the request abandons it.
    force_err = 1;
    dREN = 1'b1; dWEN = 1'b0; daddr = 32'h300;
    @(posedge CLK); #1;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK); #1;
      check("err_dwait_held", word_t'(dwait), 32'd1);
      check("err_ramREN_held", word_t'(ramREN), 32'd1);
    end
    @(posedge CLK); #1;
    dREN = 1'b0;
    @(negedge CLK); #1;
    check("ab_ramREN_drop", word_t'(ramREN), 32'd0);
    check("ab_ramWEN_drop", word_t'(ramWEN), 32'd0);
    @(posedge CLK); #1;
    force_err = 0;
    @(negedge CLK); #1;
    check("ab_idle_ramaddr", ramaddr, 32'd0);
    @(posedge CLK); #1;

    // Randomized traffic from both requesters with random RAM latency/status.
    force_lat = -1;
    fork
      begin
        for (int k = 0; k < 40; k++) begin
          int g = int'($urandom_range(0, 3));
          repeat (g) begin @(posedge CLK); #1; end
          issue_i(word_t'($urandom_range(0, 1023)) << 2);
          wait_i(300, 1'b1);
        end
      end
      begin
        for (int k = 0; k < 60; k++) begin
          int g = int'($urandom_range(0, 2));
          repeat (g) begin @(posedge CLK); #1; end
          issue_d(1'($urandom_range(0, 1)), 32'h1000 + (word_t'($urandom_range(0, 15)) << 2),
                  word_t'($urandom), 1'($urandom_range(0, 1)));
          wait_d(300, 1'b1);
        end
      end
    join

    repeat (3) @(posedge CLK);
    check("iq_drained", word_t'(iq.size()), 32'd0);
    check("dq_drained", word_t'(dq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequential arbiter that shares the single-port RAM between instruction fetch (iREN path) and data access (dREN/dWEN path) driven by the control unit.
- Sits between the request unit/caches and the RAM model.
- Owns grant FSM, request priority, completion handshake (wait signals) and an optional anti-starvation guard.

Parameters:
- MAX_DSTREAK, 4, max consecutive data grants while iREN pending before a forced instruction grant (used only with ARB_FAIRNESS_EN); legal 1..15.

Ports:
- CLK  in  1  system clock, rising edge
- nRST  in  1  asynchronous active-low reset
- iREN  in  1  instruction read request; held until iwait low
- iaddr  in  32  instruction address (word_t)
- iwait  out  1  high while instruction request pending/not complete
- iload  out  32  instruction read data; valid when iREN && !iwait
- dREN  in  1  data read request
- dWEN  in  1  data write request
- daddr  in  32  data address
- dstore  in  32  data write value
- dwait  out  1  high while data request pending/not complete
- dload  out  32  data read data; valid when dREN && !dwait
- ramREN  out  1  RAM read enable
- ramWEN  out  1  RAM write enable
- ramaddr  out  32  RAM address
- ramstore  out  32  RAM write data
- ramload  in  32  RAM read data
- ramstate  in  2  ramstate_t: FREE, BUSY, ACCESS, ERROR

Behaviour:
- States: IDLE, IGRANT, DGRANT (arb_state_t); state register is the only mandatory flop besides the streak counter.
- Reset (nRST low, async): state=IDLE, ramREN=0, ramWEN=0, ramaddr=0, ramstore=0, streak=0. iwait/dwait are combinational; they equal iREN/dREN|dWEN during reset.
- IDLE: RAM enables 0. Next edge: (dREN|dWEN) -> DGRANT; else iREN -> IGRANT; else stay. Data has priority.
- IGRANT: ramREN=1, ramWEN=0, ramaddr=iaddr. ramstate==ACCESS -> iwait=0 that cycle, iload=ramload, next=IDLE.
- DGRANT: ramaddr=daddr. dWEN -> ramWEN=1, ramstore=dstore, ramREN=0. Else ramREN=1. dWEN and dREN both high -> write only. ramstate==ACCESS -> dwait=0 that cycle, dload=ramload, next=IDLE.
- iwait = iREN && !(state==IGRANT && ramstate==ACCESS); dwait likewise for DGRANT.
- RAM outputs are combinational from state and the granted requester's inputs. Requesters hold address/data stable until their wait drops.
- Latency: minimum 2 cycles from request to completion (grant edge, then ACCESS in the same cycle). Every completion passes through IDLE, so back-to-back accesses cost one bubble cycle.
- ramstate BUSY/FREE while granted: hold state, wait stays high.
- ramstate ERROR: treated as BUSY (retry); no completion.
- Granted requester deasserts its request before ACCESS (abandon): next edge -> IDLE. RAM enables drop combinationally that cycle.
- Simultaneous iREN and data request in IDLE: data wins. iwait stays high; instruction granted after the data completes.
- Reset mid-grant: immediate return to IDLE, enables drop asynchronously.

Optional Feature:
- Macro ARB_FAIRNESS_EN.
- Defined:
  - 4-bit streak counter increments on each data completion while iREN high.
  - Clears on instruction completion or when iREN low at a data completion.
  - In IDLE with streak==MAX_DSTREAK and iREN high, IGRANT is chosen regardless of data requests.
  - Counter saturates at MAX_DSTREAK; reset 0.
- Undefined: no counter; strict data priority (instruction fetch may starve).

Decomposition:
- cpu_types_pkg: word_t, ramstate_t, and the new arb_state_t enum {IDLE, IGRANT, DGRANT}.
- A matching memory-arbiter interface (arbiter/ram/tb modports) is added alongside the control unit interface.
- No sub-module is natural. Streak logic stays inline under the macro.

Test Plan:
- Reset: nRST low with iREN=1, dREN=1 -> ramREN=ramWEN=0, state IDLE, iwait=dwait=1. Release -> DGRANT next edge.
- Single fetch: iREN=1, iaddr=0x40, ram returns ACCESS on grant cycle with ramload=0x8C220004 -> iwait low exactly 1 cycle, iload=0x8C220004, then IDLE.
- Conflict: iREN, dREN assert same cycle, daddr=0x100, RAM 2 BUSY cycles then ACCESS -> data completes first, then instruction granted after one IDLE bubble.
- Write priority: dREN=dWEN=1, dstore=0xDEADBEEF, daddr=0x200 -> ramWEN=1, ramREN=0, ramstore=0xDEADBEEF.
- ERROR/abandon: ramstate=ERROR 3 cycles -> dwait held high. Then drop dREN -> IDLE next edge, enables 0.
- ARB_FAIRNESS_EN, MAX_DSTREAK=4: iREN held plus continuous data requests -> exactly 4 data completions, then instruction grant, streak cleared.
